// File: rtl/matmul_ctrl_param.sv
// ---------------------------------------------------------------------------
// matmul_ctrl_param
// Sequencing controller for a matrix-multiply engine computing
// C[MxP] = A[MxN] x B[NxP], or C += A x B when acc_mode is set at start.
// It drives the read/write enables and row-major addresses of the three
// operand memories, and the load/clear strobes of the MAC accumulator.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, aborts any operation
//   start     in   begin one full multiply (sampled only in IDLE)
//   acc_mode  in   1: preload old C and accumulate; latched with start
//   a_rEN     out  read enable, memory A
//   b_rEN     out  read enable, memory B
//   c_rEN     out  read enable, memory C (preload)
//   c_wEN     out  write enable, memory C
//   addr_a    out  A address i*N+k
//   addr_b    out  B address k*P+j
//   addr_c    out  C address i*P+j
//   mac_en    out  accumulator captures a product this cycle
//   mac_clr   out  with mac_en: load the product instead of adding
//   acc_ld    out  accumulator loads memory-C read data
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//
// Timing per element: [PRELOAD] ISSUE x N, DRAIN x (1+MUL_LAT), WRITE.
// All outputs are registered; they are set on entry to the state in which
// they must be visible.
// ---------------------------------------------------------------------------
module matmul_ctrl_param #(
    parameter int M       = 4,
    parameter int N       = 3,
    parameter int P       = 4,
    parameter int MUL_LAT = 2,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          acc_mode,
    output logic          a_rEN,
    output logic          b_rEN,
    output logic          c_rEN,
    output logic          c_wEN,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-1:0] addr_c,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          acc_ld,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t        state_q;
    logic          acc_mode_q;
    logic [AW-1:0] j_q;         // column of the current C element
    logic [AW-1:0] k_q;         // dot-product index within ISSUE
    logic [AW-1:0] row_a_q;     // i*N, base of the current A row
    logic [AW-1:0] elem_q;      // i*P+j, C address of the current element
    logic [2:0]    drain_q;
    logic          a_ren_q;
    logic          b_ren_q;
    logic          c_ren_q;
    logic          c_wen_q;
    logic          busy_q;
    logic          done_q;
    logic          acc_ld_q;
    logic [AW-1:0] addr_a_q;
    logic [AW-1:0] addr_b_q;
    logic [AW-1:0] addr_c_q;

    // Delay line carrying "a product was read" plus its clear flag
    logic [MUL_LAT:0] mac_pipe_q;
    logic [MUL_LAT:0] clr_pipe_q;

    // Counters for the element that follows the current one
    logic          last_col_d;
    logic          last_elem_d;
    logic [AW-1:0] next_j_d;
    logic [AW-1:0] next_row_d;
    logic [AW-1:0] next_elem_d;

    always_comb begin
        last_col_d  = (j_q == AW'(P - 1));
        last_elem_d = (elem_q == AW'(M * P - 1));
        next_j_d    = last_col_d ? '0 : j_q + AW'(1);
        next_row_d  = last_col_d ? row_a_q + AW'(N) : row_a_q;
        next_elem_d = elem_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_mode_q <= 1'b0;
            j_q        <= '0;
            k_q        <= '0;
            row_a_q    <= '0;
            elem_q     <= '0;
            drain_q    <= '0;
            a_ren_q    <= 1'b0;
            b_ren_q    <= 1'b0;
            c_ren_q    <= 1'b0;
            c_wen_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            addr_c_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_mode_q <= acc_mode;
                        busy_q     <= 1'b1;
                        j_q        <= '0;
                        k_q        <= '0;
                        row_a_q    <= '0;
                        elem_q     <= '0;
                        if (acc_mode) begin
                            state_q  <= PRELOAD;
                            c_ren_q  <= 1'b1;
                            addr_c_q <= '0;
                        end else begin
                            state_q  <= ISSUE;
                            a_ren_q  <= 1'b1;
                            b_ren_q  <= 1'b1;
                            addr_a_q <= '0;
                            addr_b_q <= '0;
                        end
                    end
                end
                PRELOAD: begin
                    c_ren_q  <= 1'b0;
                    state_q  <= ISSUE;
                    a_ren_q  <= 1'b1;
                    b_ren_q  <= 1'b1;
                    addr_a_q <= row_a_q;
                    addr_b_q <= j_q;
                    k_q      <= '0;
                end
                ISSUE: begin
                    if (k_q == AW'(N - 1)) begin
                        a_ren_q <= 1'b0;
                        b_ren_q <= 1'b0;
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        // Next k: A steps along the row, B steps down the column
                        k_q      <= k_q + AW'(1);
                        addr_a_q <= addr_a_q + AW'(1);
                        addr_b_q <= addr_b_q + AW'(P);
                    end
                end
                DRAIN: begin
                    // Last product reaches the accumulator in the final DRAIN cycle
                    if (drain_q == 3'(MUL_LAT)) begin
                        state_q  <= WRITE;
                        c_wen_q  <= 1'b1;
                        addr_c_q <= elem_q;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                WRITE: begin
                    c_wen_q <= 1'b0;
                    if (last_elem_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        j_q     <= next_j_d;
                        row_a_q <= next_row_d;
                        elem_q  <= next_elem_d;
                        k_q     <= '0;
                        if (acc_mode_q) begin
                            state_q  <= PRELOAD;
                            c_ren_q  <= 1'b1;
                            addr_c_q <= next_elem_d;
                        end else begin
                            state_q  <= ISSUE;
                            a_ren_q  <= 1'b1;
                            b_ren_q  <= 1'b1;
                            addr_a_q <= next_row_d;
                            addr_b_q <= next_j_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // First stage: memory read latency. acc_ld follows c_rEN by that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_pipe_q[0] <= 1'b0;
            clr_pipe_q[0] <= 1'b0;
            acc_ld_q      <= 1'b0;
        end else begin
            mac_pipe_q[0] <= a_ren_q;
            // Only the k=0 product restarts the sum, and never when accumulating onto old C
            clr_pipe_q[0] <= a_ren_q && (k_q == '0) && !acc_mode_q;
            acc_ld_q      <= c_ren_q;
        end
    end

    // Remaining stages match the multiplier register depth
    genvar gi;
    generate
        for (gi = 1; gi <= MUL_LAT; gi++) begin : g_mac_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    mac_pipe_q[gi] <= 1'b0;
                    clr_pipe_q[gi] <= 1'b0;
                end else begin
                    mac_pipe_q[gi] <= mac_pipe_q[gi-1];
                    clr_pipe_q[gi] <= clr_pipe_q[gi-1];
                end
            end
        end
    endgenerate

    assign a_rEN   = a_ren_q;
    assign b_rEN   = b_ren_q;
    assign c_rEN   = c_ren_q;
    assign c_wEN   = c_wen_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign addr_c  = addr_c_q;
    assign mac_en  = mac_pipe_q[MUL_LAT];
    assign mac_clr = clr_pipe_q[MUL_LAT];
    assign acc_ld  = acc_ld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
